// File: rtl/serial_alu.sv
// Bit-serial ALU: one bit per clock, LSB first, through a single 1-bit slice.
// Result and NZCV flags are registered and only change when an operation completes.
module serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, res_q, res_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d, done_q, done_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

  logic             ai, bi, bx, arith, valid, s, cout, ov, lt, last;
  logic [WIDTH-1:0] full, fin;

  // Single-bit slice plus the MSB overflow/set-less-than equations
  always_comb begin
    ai    = a_q[0];
    bi    = b_q[0];
    bx    = bi ^ ctrl_q[0];
    arith = (ctrl_q == 3'b000) || (ctrl_q == 3'b001) || (ctrl_q == 3'b101);
    valid = arith || (ctrl_q == 3'b010) || (ctrl_q == 3'b011);
    cout  = (ai & bx) | (ai & cy_q) | (bx & cy_q);
    case (ctrl_q)
      3'b000, 3'b001, 3'b101: s = ai ^ bx ^ cy_q;
      3'b010:                 s = ai & bi;
      3'b011:                 s = ai | bi;
      default:                s = 1'b0;
    endcase
    ov   = ~(ctrl_q[0] ^ bi ^ ai) & (s ^ ai) & ~ctrl_q[1];
    lt   = s ^ ov;
    full = {s, sh_q[WIDTH-1:1]};
    last = (cnt_q == CW'(WIDTH - 1));
    if (ctrl_q == 3'b101)
      fin = WIDTH'(lt);
    else if (valid)
      fin = full;
    else
      fin = '0;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    sh_d    = sh_q;
    res_d   = res_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ctrl_d  = ALUControl;
          cnt_d   = '0;
          cy_d    = ALUControl[0];
          sh_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        sh_d  = full;
        cnt_d = cnt_q + 1'b1;
        if (arith) cy_d = cout;
        if (last) begin
          // Undefined codes fall through with fin=0 and all other flags cleared
          res_d   = fin;
          z_d     = (fin == '0);
          n_d     = fin[WIDTH-1];
          c_d     = arith ? cout : 1'b0;
          v_d     = valid ? ov : 1'b0;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sh_q    <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign Result   = res_q;
  assign Zero     = z_q;
  assign Negative = n_q;
  assign Carry    = c_q;
  assign Overflow = v_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu at WIDTH=32 with hand-computed expected results.
module tb_serial_alu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  ALUControl = '0;
  logic        busy, done, Zero, Negative, Carry, Overflow;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  serial_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .ALUControl(ALUControl), .busy(busy), .done(done), .Result(Result),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single accepting edge; returns at the following negedge
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] op);
    @(negedge clk);
    a = av; b = bv; ALUControl = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Flags packed as {Z,N,C,V}
  function automatic logic [31:0] flags();
    return {28'd0, Zero, Negative, Carry, Overflow};
  endfunction

  initial begin
    #12;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset result", Result, 32'd0);
    checkOutput("reset flags", flags(), 32'd0);
    reset_n = 1'b1;

    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 3'b000);
    checkOutput("add busy", {31'd0, busy}, 32'd1);
    waitDone(lat);
    checkOutput("add latency", lat + 1, 33);
    checkOutput("add busy in done", {31'd0, busy}, 32'd0);
    checkOutput("add result", Result, 32'h8000_0000);
    checkOutput("add flags", flags(), 32'b0101);
    @(negedge clk);
    checkOutput("done pulse width", {31'd0, done}, 32'd0);
    checkOutput("add result hold", Result, 32'h8000_0000);

    applyStimulus(32'd5, 32'd5, 3'b001);
    waitDone(lat);
    checkOutput("sub result", Result, 32'd0);
    checkOutput("sub flags", flags(), 32'b1010);

    // -1 - 1 produces an unsigned carry-out, so only result/Z/N/V are checked here
    applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b101);
    waitDone(lat);
    checkOutput("slt neg result", Result, 32'd1);
    checkOutput("slt neg ZNV", {Zero, Negative, Overflow}, 32'b000);

    applyStimulus(32'h8000_0000, 32'd1, 3'b101);
    waitDone(lat);
    checkOutput("slt ovf result", Result, 32'd1);
    checkOutput("slt ovf flags", flags(), 32'b0011);

    applyStimulus(32'd3, 32'd2, 3'b101);
    waitDone(lat);
    checkOutput("slt false result", Result, 32'd0);
    checkOutput("slt false flags", flags(), 32'b1010);

    applyStimulus(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010);
    waitDone(lat);
    checkOutput("and result", Result, 32'h00F0_00F0);
    checkOutput("and flags", flags(), 32'b0000);

    applyStimulus(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011);
    waitDone(lat);
    checkOutput("or result", Result, 32'hFFF0_FFF0);
    checkOutput("or flags", flags(), 32'b0100);

    applyStimulus(32'hDEAD_BEEF, 32'h1234_5678, 3'b110);
    waitDone(lat);
    checkOutput("undef latency", lat + 1, 33);
    checkOutput("undef result", Result, 32'd0);
    checkOutput("undef flags", flags(), 32'b1000);

    // start pulses while busy must not resample operands
    applyStimulus(32'd10, 32'd20, 3'b000);
    repeat (3) @(negedge clk);
    a = 32'd1000; b = 32'd2000; ALUControl = 3'b011; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    waitDone(lat);
    checkOutput("busy start result", Result, 32'd30);

    applyStimulus(32'd1, 32'd2, 3'b000);
    waitDone(lat);
    checkOutput("b2b first result", Result, 32'd3);
    a = 32'd100; b = 32'd23; ALUControl = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b accepted", {31'd0, busy}, 32'd1);
    waitDone(lat);
    checkOutput("b2b latency", lat + 1, 33);
    checkOutput("b2b second result", Result, 32'd123);

    applyStimulus(32'h0000_0F00, 32'h0000_00FF, 3'b001);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort result", Result, 32'd0);
    checkOutput("abort flags", flags(), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checkOutput("abort no done", seen, 0);

    applyStimulus(32'd1, 32'd1, 3'b000);
    waitDone(lat);
    checkOutput("post reset result", Result, 32'd2);
    checkOutput("post reset flags", flags(), 32'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
